// File: rtl/sort_seq_ctrl.sv
// Sequencer for an external sorter array: streams a job into the cells, pulses start,
// waits for the run indication to fall (or times out), then streams the cells back out.
module sort_seq_ctrl #(
    parameter int unsigned N_WORDS = 8,
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               in_data,
    output logic                       ld_en,
    output logic [$clog2(N_WORDS)-1:0] ld_idx,
    output logic [W-1:0]               ld_data,
    output logic                       start_o,
    input  logic                       run_i,
    input  logic [W-1:0]               rd_data_i,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic                       out_last,
    output logic                       busy_o,
    output logic                       err_timeout_o
);

    localparam int unsigned IW = $clog2(N_WORDS);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_WORDS - 1);
    localparam logic [TW-1:0] TMR_END  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {LOAD, START, SORT, UNLOAD} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            seen_run_q, seen_run_d;
    logic            err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            cnt_q      <= '0;
            tmr_q      <= '0;
            seen_run_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            seen_run_q <= seen_run_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        seen_run_d = seen_run_q;
        err_d      = err_q;
        in_ready   = 1'b0;
        ld_en      = 1'b0;
        ld_idx     = cnt_q;
        ld_data    = in_data;
        start_o    = 1'b0;
        out_valid  = 1'b0;
        out_data   = rd_data_i;
        out_last   = 1'b0;
        busy_o     = 1'b1;

        unique case (state_q)
            LOAD: begin
                busy_o   = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    ld_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '0) err_d = 1'b0;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = START;
                    end
                end
            end
            START: begin
                start_o    = 1'b1;
                tmr_d      = '0;
                seen_run_d = 1'b0;
                state_d    = SORT;
            end
            SORT: begin
                if (run_i) seen_run_d = 1'b1;
                if (tmr_q != '1) tmr_d = tmr_q + 1'b1;
                // Completion is checked first so it wins over a coincident timeout.
                if (seen_run_q && !run_i) begin
                    cnt_d   = '0;
                    state_d = UNLOAD;
                end else if (tmr_q == TMR_END) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = LOAD;
                end
            end
            UNLOAD: begin
                out_valid = 1'b1;
                out_last  = (cnt_q == LAST_IDX);
                if (out_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Directed bench for sort_seq_ctrl: a behavioural sorter array drives rd_data_i,
// a second instance with a short TIMEOUT exercises the abort path.
module tb_sort_seq_ctrl;

    typedef logic [7:0] vec_t [8];

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [7:0] in_data;
    logic       ld_en;
    logic [2:0] ld_idx;
    logic [7:0] ld_data;
    logic       start_o, run_i;
    logic [7:0] rd_data_i;
    logic       out_valid, out_ready;
    logic [7:0] out_data;
    logic       out_last, busy_o, err_timeout_o;

    logic       t_in_valid, t_in_ready;
    logic [7:0] t_in_data;
    logic       t_ld_en;
    logic [2:0] t_ld_idx;
    logic [7:0] t_ld_data;
    logic       t_start, t_out_valid, t_out_last, t_busy, t_err;
    logic [7:0] t_out_data;

    logic [7:0] mem [8];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rd_data_i = mem[ld_idx];

    sort_seq_ctrl #(.N_WORDS(8), .W(8), .TIMEOUT(1024)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
        .start_o(start_o), .run_i(run_i), .rd_data_i(rd_data_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy_o(busy_o), .err_timeout_o(err_timeout_o)
    );

    sort_seq_ctrl #(.N_WORDS(8), .W(8), .TIMEOUT(16)) dut_to (
        .clk(clk), .rst(rst),
        .in_valid(t_in_valid), .in_ready(t_in_ready), .in_data(t_in_data),
        .ld_en(t_ld_en), .ld_idx(t_ld_idx), .ld_data(t_ld_data),
        .start_o(t_start), .run_i(1'b0), .rd_data_i(8'h00),
        .out_valid(t_out_valid), .out_ready(1'b1), .out_data(t_out_data),
        .out_last(t_out_last), .busy_o(t_busy), .err_timeout_o(t_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; run_i = 1'b0; out_ready = 1'b0;
        t_in_valid = 1'b0; t_in_data = '0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy_o !== 1'b0 || err_timeout_o !== 1'b0 ||
            start_o !== 1'b0 || out_valid !== 1'b0 || ld_en !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b busy=%b err=%b start=%b ov=%b ld_en=%b last=%b, required 1 0 0 0 0 0 0",
                     in_ready, busy_o, err_timeout_o, start_o, out_valid, ld_en, out_last);
        end
        tick();
    endtask

    // Streams 8 words in; with gaps set, every third cycle drops in_valid.
    task automatic load_job(input vec_t vals, input bit gaps);
        int unsigned k = 0;
        int unsigned c = 0;
        while (k < 8 && c < 50) begin
            if (gaps && (c % 3 == 1)) begin
                in_valid = 1'b0;
                @(negedge clk);
                checks++;
                if (ld_en !== 1'b0) begin
                    errors++;
                    $display("FAIL load_gap: ld_en=%b required 0", ld_en);
                end
            end else begin
                in_valid = 1'b1;
                in_data  = vals[k];
                @(negedge clk);
                checks++;
                if (in_ready !== 1'b1 || ld_en !== 1'b1 || ld_idx !== 3'(k) || ld_data !== vals[k]) begin
                    errors++;
                    $display("FAIL load_word%0d: in_ready=%b ld_en=%b ld_idx=%0d ld_data=%0d, required 1 1 %0d %0d",
                             k, in_ready, ld_en, ld_idx, ld_data, k, vals[k]);
                end
                mem[ld_idx] = ld_data;
                k++;
            end
            tick();
            c++;
        end
        in_valid = 1'b0;
        checks++;
        if (k != 8) begin
            errors++;
            $display("FAIL load_budget: loaded %0d required 8", k);
        end
    endtask

    task automatic run_sort(input int unsigned hi_cycles);
        @(negedge clk);
        checks++;
        if (start_o !== 1'b1 || in_ready !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse: start=%b in_ready=%b busy=%b, required 1 0 1", start_o, in_ready, busy_o);
        end
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7 - i; j++)
                if (mem[j] > mem[j+1]) begin
                    logic [7:0] t;
                    t = mem[j]; mem[j] = mem[j+1]; mem[j+1] = t;
                end
        tick();
        run_i = 1'b1;
        for (int unsigned i = 0; i < hi_cycles; i++) begin
            @(negedge clk);
            checks++;
            if (busy_o !== 1'b1 || start_o !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL sort_cycle%0d: busy=%b start=%b ov=%b in_ready=%b, required 1 0 0 0",
                         i, busy_o, start_o, out_valid, in_ready);
            end
            tick();
        end
        run_i = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL run_fall_cycle: ov=%b busy=%b, required 0 1", out_valid, busy_o);
        end
        tick();
    endtask

    task automatic unload_job(input vec_t exp, input logic [3:0] pat);
        int unsigned k = 0;
        int unsigned cyc = 0;
        while (k < 8 && cyc < 100) begin
            out_ready = pat[cyc % 4];
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[k] || out_last !== (k == 7) ||
                ld_idx !== 3'(k) || ld_en !== 1'b0 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL unload_word%0d: ov=%b data=%0d last=%b idx=%0d ld_en=%b busy=%b, required 1 %0d %b %0d 0 1",
                         k, out_valid, out_data, out_last, ld_idx, ld_en, busy_o, exp[k], (k == 7), k);
            end
            if (out_ready) k++;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (k != 8 || out_valid !== 1'b0 || busy_o !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL unload_end: words=%0d ov=%b busy=%b in_ready=%b, required 8 0 0 1",
                     k, out_valid, busy_o, in_ready);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        vec_t v, e;
        v = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd0, 8'd6, 8'd2, 8'd4};
        e = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        load_job(v, 1'b0);
        run_sort(40);
        unload_job(e, 4'b1111);
    endtask

    task automatic test_stall;
        vec_t v, e;
        v = '{8'd9, 8'd2, 8'd200, 8'd17, 8'd2, 8'd64, 8'd0, 8'd255};
        e = '{8'd0, 8'd2, 8'd2, 8'd9, 8'd17, 8'd64, 8'd200, 8'd255};
        load_job(v, 1'b0);
        run_sort(3);
        unload_job(e, 4'b1001);
    endtask

    task automatic test_reset_midload;
        vec_t v, e;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(100 + k);
            @(negedge clk);
            mem[ld_idx] = ld_data;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy_o !== 1'b0 || ld_en !== 1'b0 || start_o !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midload_reset: in_ready=%b busy=%b ld_en=%b start=%b ov=%b, required 1 0 0 0 0",
                     in_ready, busy_o, ld_en, start_o, out_valid);
        end
        tick();
        v = '{8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9, 8'd8};
        e = '{8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
        load_job(v, 1'b0);
        run_sort(5);
        unload_job(e, 4'b1101);
    endtask

    task automatic test_gaps;
        vec_t v, e;
        v = '{8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd0};
        e = '{8'd0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70};
        load_job(v, 1'b1);
        run_sort(2);
        unload_job(e, 4'b1111);
    endtask

    task automatic test_timeout;
        int unsigned cnt = 0;
        bit saw_ov = 0;
        for (int k = 0; k < 8; k++) begin
            t_in_valid = 1'b1;
            t_in_data  = 8'(k);
            tick();
        end
        t_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (t_start !== 1'b1) begin
            errors++;
            $display("FAIL to_start: start=%b required 1", t_start);
        end
        tick();
        while (cnt < 40) begin
            @(negedge clk);
            if (!t_busy) break;
            if (t_out_valid) saw_ov = 1;
            cnt++;
            tick();
        end
        checks++;
        if (cnt != 16 || saw_ov) begin
            errors++;
            $display("FAIL to_duration: sort cycles=%0d out_valid_seen=%0d, required 16 0", cnt, saw_ov);
        end
        checks++;
        if (t_err !== 1'b1 || t_in_ready !== 1'b1 || t_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_flag: err=%b in_ready=%b ov=%b, required 1 1 0", t_err, t_in_ready, t_out_valid);
        end
        tick();
        t_in_valid = 1'b1;
        t_in_data  = 8'd42;
        tick();
        t_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (t_err !== 1'b0) begin
            errors++;
            $display("FAIL to_clear: err=%b required 0", t_err);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_reset_midload();
        test_gaps();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
